mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 32-bit memory bus.
- Master 0 is the CPU core; master 1 is a DMA/debug port.
- Each master gets a registered request/acknowledge handshake. Round-robin arbitration decides which master drives the shared memory strobes, and a timeout aborts any transaction that `mem_ready` never completes.
- Sits between the CPU core, the DMA engine and the memory/peripheral decode. It replaces the direct CPU-to-memory connection.

---
 rtl/mem_bus_arbiter_if.sv | 58 +++++
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Two-master / one-slave memory bus bundle shared by the arbiter and its clients.
interface mem_bus_arbiter_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERRC_W = 8;

  // master 0 (CPU core)
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_err;

  // master 1 (DMA / debug)
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              m1_err;

  // shared memory side
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // status
  logic              busy;
  logic              grant;
  logic [ERRC_W-1:0] err_count;

  // arbiter view
  modport master (
    input  m0_read, m0_write, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_read, m1_write, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready,
    output busy, grant, err_count
  );

  // client / memory view
  modport slave (
    output m0_read, m0_write, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_read, m1_write, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready,
    input  busy, grant, err_count
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master memory bus arbiter with per-access timeout and registered outputs.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.master bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ERRC_W = 8;
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ERRC_W-1:0] ERRC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [ERRC_W-1:0]   errc_q, errc_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic                busy_q, busy_d;

  logic                req0, req1, winner;
  logic [DATA_W-1:0]   ret_data;

  // Next-state and next-output computation; every registered output is decided here.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    errc_d   = errc_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    busy_d   = 1'b0;

    req0     = bus.m0_read | bus.m0_write;
    req1     = bus.m1_read | bus.m1_write;
    // tie goes to the master not served last; otherwise the lone requester
    winner   = (req0 & req1) ? ~last_q : ~req0;
    ret_data = write_q ? '0 : bus.mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_ACCESS;
          grant_d = winner;
          last_d  = winner;
          write_d = winner ? bus.m1_write : bus.m0_write;
          addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
          cnt_d   = '0;
          rd_d    = winner ? ~bus.m1_write : ~bus.m0_write;
          wr_d    = winner ?  bus.m1_write :  bus.m0_write;
          busy_d  = 1'b1;
        end
      end
      S_ACCESS: begin
        busy_d = 1'b1;
        if (bus.mem_ready) begin
          // completion beats a coincident timeout
          state_d = S_RELEASE;
          if (grant_q) begin
            rdata1_d = ret_data;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = ret_data;
            ack0_d   = 1'b1;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_RELEASE;
          errc_d  = (errc_q == ERRC_MAX) ? errc_q : errc_q + 1'b1;
          if (grant_q) begin
            rdata1_d = '0;
            ack1_d   = 1'b1;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = '0;
            ack0_d   = 1'b1;
            err0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          rd_d  = ~write_q;
          wr_d  =  write_q;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      errc_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      errc_q   <= errc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.m0_rdata  = rdata0_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m1_err    = err1_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.err_count = errc_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed plan items followed by random rounds.
module tb_mem_bus_arbiter;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [1:0]  op;      // bit0 read, bit1 write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;   // value memory returns for this access
    int          wait_cycles;
  } txn_t;

  typedef struct {
    bit          master;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          cycles;
  } exp_t;

  typedef struct {
    int          wait_cycles;
    logic [31:0] data;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   model_last = 1'b1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, want, $time);
    end
  endtask

  function automatic txn_t mk(input bit req, input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mdata, input int w);
    txn_t t;
    t.req = req; t.op = op; t.addr = addr; t.wdata = wdata; t.mdata = mdata; t.wait_cycles = w;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input bit req);
    int w;
    w = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
    return mk(req, 2'($urandom_range(1, 3)), $urandom(), $urandom(), $urandom(), w);
  endfunction

  // Memory responder: raises mem_ready after the scripted number of wait cycles.
  bit   resp_active = 1'b0;
  int   resp_left   = 0;
  mem_t resp_cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_active   = 1'b0;
      bus.mem_ready = 1'b0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (!resp_active) begin
        resp_active = 1'b1;
        if (mem_q.size() > 0) resp_cur = mem_q.pop_front();
        else begin
          resp_cur.wait_cycles = NEVER;
          resp_cur.data        = '0;
        end
        resp_left = resp_cur.wait_cycles;
      end else if (resp_left > 0) begin
        resp_left--;
      end
      bus.mem_ready = (resp_left == 0);
      bus.mem_rdata = (resp_left == 0) ? resp_cur.data : $urandom();
    end else begin
      resp_active   = 1'b0;
      bus.mem_ready = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom();
    end
  end

  // Monitor: pops the expected transaction and checks bus activity and the ack cycle.
  bit          in_acc = 1'b0, prev_ack = 1'b0, prev_strobe = 1'b0;
  int          acc_cycles = 0;
  int          mdl_errs = 0;
  exp_t        cur_exp;
  logic [31:0] mdl_rdata [2] = '{32'h0, 32'h0};
  always @(negedge clk) begin
    logic strobe, a0, a1;
    strobe = bus.mem_read | bus.mem_write;
    a0     = bus.m0_ack;
    a1     = bus.m1_ack;
    if (!rst_n) begin
      in_acc = 1'b0; prev_ack = 1'b0; prev_strobe = 1'b0; acc_cycles = 0;
      mdl_errs = 0; mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    end else begin
      check1("busy", bus.busy, strobe | a0 | a1);
      check1("strobe_exclusive", bus.mem_read & bus.mem_write, 1'b0);
      if (strobe) begin
        if (!in_acc) begin
          check1("access_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) cur_exp = exp_q[0];
          check1("idle_gap", prev_ack, 1'b0);
          check1("grant", bus.grant, cur_exp.master);
          check1("op_write", bus.mem_write, cur_exp.write);
          in_acc     = 1'b1;
          acc_cycles = 0;
        end
        acc_cycles++;
        check32("mem_addr", bus.mem_addr, cur_exp.addr);
        check32("mem_wdata", bus.mem_wdata, cur_exp.wdata);
      end else if (in_acc) begin
        in_acc = 1'b0;
        check1("ack_after_strobe", a0 | a1, 1'b1);
        check32("access_cycles", 32'(acc_cycles), 32'(cur_exp.cycles));
      end
      if (a0 | a1) begin
        check1("ack_timing", prev_strobe, 1'b1);
        check1("single_ack", a0 & a1, 1'b0);
        check1("ack_master", a1, cur_exp.master);
        check1("ack_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mdl_rdata[cur_exp.master] = cur_exp.rdata;
        if (cur_exp.err) mdl_errs = (mdl_errs < 255) ? mdl_errs + 1 : 255;
        check32("m0_rdata", bus.m0_rdata, mdl_rdata[0]);
        check32("m1_rdata", bus.m1_rdata, mdl_rdata[1]);
        check1("m0_err", bus.m0_err, cur_exp.err && !cur_exp.master);
        check1("m1_err", bus.m1_err, cur_exp.err && cur_exp.master);
        check32("err_count", 32'(bus.err_count), 32'(mdl_errs));
      end else begin
        check1("err_without_ack", bus.m0_err | bus.m1_err, 1'b0);
      end
      prev_ack    = a0 | a1;
      prev_strobe = strobe;
    end
  end

  // One arbitration round: predict grant order, script memory, drive requests until acked.
  task automatic do_round(input txn_t t0, input txn_t t1);
    bit   order[$];
    bit   pend0, pend1;
    int   budget;
    txn_t t;
    exp_t e;
    if (t0.req && t1.req) begin
      order.push_back(!model_last);
      order.push_back(model_last);
    end else if (t0.req) begin
      order.push_back(1'b0);
    end else begin
      order.push_back(1'b1);
    end
    model_last = order[order.size() - 1];
    foreach (order[i]) begin
      t        = order[i] ? t1 : t0;
      e.master = order[i];
      e.write  = t.op[1];
      e.addr   = t.addr;
      e.wdata  = t.wdata;
      e.err    = (t.wait_cycles >= TO);
      e.cycles = e.err ? TO : t.wait_cycles + 1;
      e.rdata  = (e.write || e.err) ? 32'h0 : t.mdata;
      exp_q.push_back(e);
      mem_q.push_back('{t.wait_cycles, t.mdata});
    end
    @(negedge clk);
    bus.m0_read  = t0.req & t0.op[0];
    bus.m0_write = t0.req & t0.op[1];
    bus.m0_addr  = t0.addr;
    bus.m0_wdata = t0.wdata;
    bus.m1_read  = t1.req & t1.op[0];
    bus.m1_write = t1.req & t1.op[1];
    bus.m1_addr  = t1.addr;
    bus.m1_wdata = t1.wdata;
    pend0  = t0.req;
    pend1  = t1.req;
    budget = 0;
    while ((pend0 || pend1) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (pend0 && bus.m0_ack) begin
        pend0 = 1'b0; bus.m0_read = 1'b0; bus.m0_write = 1'b0;
      end
      if (pend1 && bus.m1_ack) begin
        pend1 = 1'b0; bus.m1_read = 1'b0; bus.m1_write = 1'b0;
      end
    end
    check32("round_done", {30'h0, pend1, pend0}, 32'h0);
    bus.m0_read = 1'b0; bus.m0_write = 1'b0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0;
    repeat (1 + $urandom_range(0, 1)) @(negedge clk);
  endtask

  txn_t none;

  initial begin
    none = mk(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_grant", bus.grant, 1'b0);
    check1("rst_mem_read", bus.mem_read, 1'b0);
    check1("rst_mem_write", bus.mem_write, 1'b0);
    check1("rst_m0_ack", bus.m0_ack, 1'b0);
    check1("rst_m1_ack", bus.m1_ack, 1'b0);
    check32("rst_err_count", 32'(bus.err_count), 32'h0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check32("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check32("rst_m1_rdata", bus.m1_rdata, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;

    // single zero-wait read by m0
    do_round(mk(1'b1, 2'b01, 32'h100, 32'h0, 32'hCAFEF00D, 0), none);
    // ties held by both masters: grants alternate 0,1,0,1
    do_round(mk(1'b1, 2'b01, 32'h10, 32'h0, 32'h11111111, 0),
             mk(1'b1, 2'b10, 32'h20, 32'h22222222, 32'h0, 1));
    do_round(mk(1'b1, 2'b10, 32'h30, 32'h33333333, 32'h0, 2),
             mk(1'b1, 2'b01, 32'h40, 32'h0, 32'h44444444, 0));
    // m1 write with three wait states
    do_round(none, mk(1'b1, 2'b10, 32'h2000, 32'h12345678, 32'h0, 3));
    // timeout, then ready on the final permitted cycle
    do_round(mk(1'b1, 2'b01, 32'h500, 32'h0, 32'hDEADBEEF, NEVER), none);
    do_round(mk(1'b1, 2'b01, 32'h504, 32'h0, 32'h0BADF00D, TO - 1), none);
    // read and write both asserted acts as a write
    do_round(mk(1'b1, 2'b11, 32'h600, 32'hA5A5A5A5, 32'hFFFFFFFF, 0), none);

    // reset during ACCESS
    exp_q.push_back('{1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, TO});
    mem_q.push_back('{NEVER, 32'h0});
    @(negedge clk);
    bus.m0_read = 1'b1; bus.m0_addr = 32'h300; bus.m0_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk); #2;
    check1("pre_rst_busy", bus.busy, 1'b1);
    check1("pre_rst_mem_read", bus.mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_mem_read", bus.mem_read, 1'b0);
    check1("midrst_mem_write", bus.mem_write, 1'b0);
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_m0_ack", bus.m0_ack, 1'b0);
    check32("midrst_err_count", 32'(bus.err_count), 32'h0);
    bus.m0_read = 1'b0;
    exp_q.delete();
    mem_q.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    do_round(mk(1'b1, 2'b01, 32'h700, 32'h0, 32'h77777777, 0),
             mk(1'b1, 2'b01, 32'h800, 32'h0, 32'h88888888, 0));

    // randomized mix
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(1, 3));
      do_round(rnd_txn(r[0]), rnd_txn(r[1]));
    end

    // drive err_count into saturation
    for (int i = 0; i < 256; i++) begin
      do_round(none, mk(1'b1, 2'b01, $urandom(), $urandom(), $urandom(), NEVER));
    end
    check32("err_count_sat", 32'(bus.err_count), 32'd255);
    check32("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
